// File: rtl/bcd_range_counter_if.sv
// Control and data bundle for one bcd_range_counter digit pair.
// The master drives the count controls; the slave (the counter) returns Q and flags.
interface bcd_range_counter_if;
  logic       EN;
  logic       CLR;
  logic       UP;
  logic       LD;
  logic [3:0] DH;
  logic [3:0] DL;
  logic [3:0] QH;
  logic [3:0] QL;
  logic       CA;
  logic       BW;
  logic       LDERR;

  modport master (
    output EN, CLR, UP, LD, DH, DL,
    input  QH, QL, CA, BW, LDERR
  );

  modport slave (
    input  EN, CLR, UP, LD, DH, DL,
    output QH, QL, CA, BW, LDERR
  );
endinterface

// File: rtl/bcd_range_counter.sv
// Two-digit BCD up/down counter over MIN..MAX with load, clear and
// same-cycle carry/borrow so stages can be chained CA/BW -> EN.
module bcd_range_counter #(
  parameter int MIN = 0,
  parameter int MAX = 59
) (
  input  logic               CLK,
  input  logic               RST,
  bcd_range_counter_if.slave bus
);

  localparam logic [3:0] MIN_TENS  = 4'(MIN / 10);
  localparam logic [3:0] MIN_UNITS = 4'(MIN % 10);
  localparam logic [3:0] MAX_TENS  = 4'(MAX / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX % 10);
  localparam logic [7:0] MIN_BIN   = 8'(MIN);
  localparam logic [7:0] MAX_BIN   = 8'(MAX);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_REJECT,
    OP_INC,
    OP_DEC
  } op_e;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Eight bits so that non-BCD load digits (up to 15) cannot overflow.
  function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'd0, tens} * 8'd10) + {4'd0, units};
  endfunction

  logic [3:0] qh_r;
  logic [3:0] ql_r;
  logic       lderr_r;
  logic [3:0] qh_nxt_s;
  logic [3:0] ql_nxt_s;
  logic       lderr_nxt_s;
  logic [7:0] value_s;
  logic [7:0] load_value_s;
  logic       at_max_s;
  logic       at_min_s;
  logic       load_ok_s;
  logic       ca_s;
  logic       bw_s;
  op_e        op_s;

  assign value_s      = bcd_to_bin(qh_r, ql_r);
  assign load_value_s = bcd_to_bin(bus.DH, bus.DL);
  assign at_max_s     = (value_s == MAX_BIN);
  assign at_min_s     = (value_s == MIN_BIN);
  assign load_ok_s    = is_bcd_digit(bus.DH) && is_bcd_digit(bus.DL) &&
                        (load_value_s >= MIN_BIN) && (load_value_s <= MAX_BIN);

  // Resolve the CLR > LD > EN priority into a single operation for this edge.
  always_comb begin
    op_s = OP_HOLD;
    if (bus.CLR) begin
      op_s = OP_CLR;
    end else if (bus.LD) begin
      if (load_ok_s) begin
        op_s = OP_LOAD;
      end else begin
        op_s = OP_REJECT;
      end
    end else if (bus.EN) begin
      if (bus.UP) begin
        op_s = OP_INC;
      end else begin
        op_s = OP_DEC;
      end
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next count digits and load-error flag for the selected operation.
  always_comb begin
    qh_nxt_s    = qh_r;
    ql_nxt_s    = ql_r;
    lderr_nxt_s = 1'b0;
    case (op_s)
      OP_CLR: begin
        qh_nxt_s = MIN_TENS;
        ql_nxt_s = MIN_UNITS;
      end
      OP_LOAD: begin
        qh_nxt_s = bus.DH;
        ql_nxt_s = bus.DL;
      end
      OP_REJECT: begin
        lderr_nxt_s = 1'b1;
      end
      OP_INC: begin
        if (at_max_s) begin
          qh_nxt_s = MIN_TENS;
          ql_nxt_s = MIN_UNITS;
        end else if (ql_r == 4'd9) begin
          qh_nxt_s = qh_r + 4'd1;
          ql_nxt_s = 4'd0;
        end else begin
          ql_nxt_s = ql_r + 4'd1;
        end
      end
      OP_DEC: begin
        if (at_min_s) begin
          qh_nxt_s = MAX_TENS;
          ql_nxt_s = MAX_UNITS;
        end else if (ql_r == 4'd0) begin
          qh_nxt_s = qh_r - 4'd1;
          ql_nxt_s = 4'd9;
        end else begin
          ql_nxt_s = ql_r - 4'd1;
        end
      end
      OP_HOLD: begin
        qh_nxt_s = qh_r;
        ql_nxt_s = ql_r;
      end
      default: begin
        qh_nxt_s = MIN_TENS;
        ql_nxt_s = MIN_UNITS;
      end
    endcase
  end

  // Count and load-error registers; RST wins over every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      qh_r    <= MIN_TENS;
      ql_r    <= MIN_UNITS;
      lderr_r <= 1'b0;
    end else begin
      qh_r    <= qh_nxt_s;
      ql_r    <= ql_nxt_s;
      lderr_r <= lderr_nxt_s;
    end
  end

  // Flags are combinational so the next stage steps on the same edge as the wrap.
  assign ca_s = bus.EN &  bus.UP & ~bus.CLR & ~bus.LD & at_max_s;
  assign bw_s = bus.EN & ~bus.UP & ~bus.CLR & ~bus.LD & at_min_s;

  assign bus.QH    = qh_r;
  assign bus.QL    = ql_r;
  assign bus.LDERR = lderr_r;
  assign bus.CA    = ca_s;
  assign bus.BW    = bw_s;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Randomised and directed bench for bcd_range_counter against an integer-valued
// reference model; covers 0..59, 1..12, 0..23 and a two-stage cascade.
module tb_bcd_range_counter;

  typedef struct packed {
    logic       clr;
    logic       ld;
    logic [3:0] dh;
    logic [3:0] dl;
    logic       en;
    logic       up;
  } stim_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bcd_range_counter_if if_a ();
  bcd_range_counter_if if_b ();
  bcd_range_counter_if if_c ();
  bcd_range_counter_if if_s ();
  bcd_range_counter_if if_m ();

  bcd_range_counter #(.MIN(0), .MAX(59)) u_a (.CLK(CLK), .RST(RST), .bus(if_a));
  bcd_range_counter #(.MIN(1), .MAX(12)) u_b (.CLK(CLK), .RST(RST), .bus(if_b));
  bcd_range_counter #(.MIN(0), .MAX(23)) u_c (.CLK(CLK), .RST(RST), .bus(if_c));
  bcd_range_counter #(.MIN(0), .MAX(59)) u_s (.CLK(CLK), .RST(RST), .bus(if_s));
  bcd_range_counter #(.MIN(0), .MAX(59)) u_m (.CLK(CLK), .RST(RST), .bus(if_m));

  assign if_m.EN = if_s.CA;

  int n_checks = 0;
  int n_pass   = 0;
  int mv[5];
  int mmin[5] = '{0, 1, 0, 0, 0};
  int mmax[5] = '{59, 12, 23, 59, 59};

  function automatic stim_t mk(logic clr, logic ld, logic [3:0] dh, logic [3:0] dl, logic en, logic up);
    stim_t s;
    s.clr = clr; s.ld = ld; s.dh = dh; s.dl = dl; s.en = en; s.up = up;
    return s;
  endfunction

  function automatic logic [7:0] to_bcd(int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Reference model on the plain integer value.
  function automatic void model_next(input int v, input int mn, input int mx, input stim_t s,
                                     output int nv, output logic nerr);
    int d;
    d    = int'(s.dh) * 10 + int'(s.dl);
    nv   = v;
    nerr = 1'b0;
    if (s.clr) nv = mn;
    else if (s.ld) begin
      if (s.dh <= 4'd9 && s.dl <= 4'd9 && d >= mn && d <= mx) nv = d;
      else nerr = 1'b1;
    end else if (s.en) begin
      if (s.up) nv = (v == mx) ? mn : v + 1;
      else      nv = (v == mn) ? mx : v - 1;
    end
  endfunction

  function automatic logic model_ca(int v, int mx, stim_t s);
    return s.en && s.up && !s.clr && !s.ld && (v == mx);
  endfunction

  function automatic logic model_bw(int v, int mn, stim_t s);
    return s.en && !s.up && !s.clr && !s.ld && (v == mn);
  endfunction

  task automatic drive(input int sel, input stim_t s);
    {if_a.CLR, if_a.LD, if_a.DH, if_a.DL, if_a.EN, if_a.UP} = 12'd0;
    {if_b.CLR, if_b.LD, if_b.DH, if_b.DL, if_b.EN, if_b.UP} = 12'd0;
    {if_c.CLR, if_c.LD, if_c.DH, if_c.DL, if_c.EN, if_c.UP} = 12'd0;
    {if_s.CLR, if_s.LD, if_s.DH, if_s.DL, if_s.EN, if_s.UP} = 12'd0;
    {if_m.CLR, if_m.LD, if_m.DH, if_m.DL, if_m.UP} = 11'd0;
    case (sel)
      0: {if_a.CLR, if_a.LD, if_a.DH, if_a.DL, if_a.EN, if_a.UP} = s;
      1: {if_b.CLR, if_b.LD, if_b.DH, if_b.DL, if_b.EN, if_b.UP} = s;
      2: {if_c.CLR, if_c.LD, if_c.DH, if_c.DL, if_c.EN, if_c.UP} = s;
      3: {if_s.CLR, if_s.LD, if_s.DH, if_s.DL, if_s.EN, if_s.UP} = s;
      4: {if_m.CLR, if_m.LD, if_m.DH, if_m.DL, if_m.UP} = {s[11:2], s[0]};
      default: ;
    endcase
  endtask

  task automatic observe(input int sel, output logic [7:0] q, output logic ca, output logic bw,
                         output logic err);
    case (sel)
      0: begin q = {if_a.QH, if_a.QL}; ca = if_a.CA; bw = if_a.BW; err = if_a.LDERR; end
      1: begin q = {if_b.QH, if_b.QL}; ca = if_b.CA; bw = if_b.BW; err = if_b.LDERR; end
      2: begin q = {if_c.QH, if_c.QL}; ca = if_c.CA; bw = if_c.BW; err = if_c.LDERR; end
      3: begin q = {if_s.QH, if_s.QL}; ca = if_s.CA; bw = if_s.BW; err = if_s.LDERR; end
      default: begin q = {if_m.QH, if_m.QL}; ca = if_m.CA; bw = if_m.BW; err = if_m.LDERR; end
    endcase
  endtask

  // Called just after a rising edge: flags sampled at the falling edge, Q after the next rise.
  task automatic step(input int sel, input stim_t s, output logic ca, output logic bw,
                      output logic [7:0] q, output logic err);
    logic [7:0] q0;
    logic       e0, c1, b1;
    drive(sel, s);
    @(negedge CLK);
    observe(sel, q0, ca, bw, e0);
    @(posedge CLK);
    #1;
    observe(sel, q, c1, b1, err);
  endtask

  task automatic do_reset(input stim_t s, input int sel);
    drive(sel, s);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 5; i++) mv[i] = mmin[i];
  endtask

  task automatic test_reset();
    logic [7:0] q;
    logic ca, bw, err;
    do_reset(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0), -1);
    for (int i = 0; i < 5; i++) begin
      observe(i, q, ca, bw, err);
      n_checks++;
      if (q !== to_bcd(mmin[i]) || err !== 1'b0)
        $display("FAIL reset[%0d] got Q=%h LDERR=%b want Q=%h LDERR=0", i, q, err, to_bcd(mmin[i]));
      else n_pass++;
    end
  endtask

  // Runs a stimulus list on one instance, checking flags, Q and LDERR every cycle.
  task automatic test_seq(input string tag, input int sel, input stim_t v[$]);
    logic [7:0] q;
    logic ca, bw, err, e_ca, e_bw, nerr;
    int nv;
    foreach (v[i]) begin
      e_ca = model_ca(mv[sel], mmax[sel], v[i]);
      e_bw = model_bw(mv[sel], mmin[sel], v[i]);
      model_next(mv[sel], mmin[sel], mmax[sel], v[i], nv, nerr);
      step(sel, v[i], ca, bw, q, err);
      mv[sel] = nv;
      n_checks++;
      if (ca !== e_ca) $display("FAIL %s[%0d] CA got %b want %b", tag, i, ca, e_ca); else n_pass++;
      n_checks++;
      if (bw !== e_bw) $display("FAIL %s[%0d] BW got %b want %b", tag, i, bw, e_bw); else n_pass++;
      n_checks++;
      if (q !== to_bcd(nv)) $display("FAIL %s[%0d] Q got %h want %h", tag, i, q, to_bcd(nv)); else n_pass++;
      n_checks++;
      if (err !== nerr) $display("FAIL %s[%0d] LDERR got %b want %b", tag, i, err, nerr); else n_pass++;
    end
  endtask

  task automatic test_count_up();
    stim_t v[$];
    for (int i = 0; i < 60; i++) v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1));
    test_seq("count_up", 0, v);
  endtask

  task automatic test_range_1_12();
    stim_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd1, 4'd3, 1'b0, 1'b0));
    test_seq("range_1_12", 1, v);
  endtask

  task automatic test_load();
    stim_t v[$];
    v.push_back(mk(1'b0, 1'b1, 4'd4, 4'd7, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd3, 4'hA, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'hA, 4'd3, 1'b1, 1'b1));
    v.push_back(mk(1'b0, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0));
    test_seq("load", 0, v);
  endtask

  task automatic test_priority();
    stim_t v[$];
    v.push_back(mk(1'b0, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1));
    v.push_back(mk(1'b0, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1));
    v.push_back(mk(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0));
    test_seq("priority", 0, v);
  endtask

  task automatic test_digit_wrap();
    stim_t v[$];
    v.push_back(mk(1'b0, 1'b1, 4'd1, 4'd9, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1));
    test_seq("digit_wrap", 2, v);
  endtask

  task automatic test_rst_mid();
    stim_t v[$];
    logic [7:0] q;
    logic ca, bw, err;
    v.push_back(mk(1'b0, 1'b1, 4'd3, 4'd5, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0));
    test_seq("rst_mid_pre", 0, v);
    do_reset(mk(1'b0, 1'b1, 4'd9, 4'd9, 1'b1, 1'b1), 0);
    observe(0, q, ca, bw, err);
    n_checks++;
    if (q !== 8'h00 || err !== 1'b0)
      $display("FAIL rst_mid got Q=%h LDERR=%b want Q=00 LDERR=0", q, err);
    else n_pass++;
  endtask

  task automatic test_cascade();
    stim_t v[$];
    logic [7:0] qs, qm;
    logic cs, bs, es, cm, bm, em;
    v.push_back(mk(1'b0, 1'b1, 4'd5, 4'd9, 1'b0, 1'b0));
    test_seq("cascade_ld_s", 3, v);
    test_seq("cascade_ld_m", 4, v);
    drive(3, mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1));
    if_m.UP = 1'b1;
    @(negedge CLK);
    observe(3, qs, cs, bs, es);
    observe(4, qm, cm, bm, em);
    n_checks++;
    if (cs !== 1'b1 || cm !== 1'b1) $display("FAIL cascade_ca got s=%b m=%b want 1 1", cs, cm);
    else n_pass++;
    @(posedge CLK);
    #1;
    observe(3, qs, cs, bs, es);
    observe(4, qm, cm, bm, em);
    mv[3] = 0;
    mv[4] = 0;
    n_checks++;
    if ({qm, qs} !== 16'h0000) $display("FAIL cascade_wrap got %h:%h want 00:00", qm, qs);
    else n_pass++;
  endtask

  task automatic test_random();
    stim_t v[$];
    logic [3:0] dh, dl;
    for (int sel = 0; sel < 3; sel++) begin
      v.delete();
      for (int i = 0; i < 150; i++) begin
        dh = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, mmax[sel] / 10));
        dl = ($urandom % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        v.push_back(mk(1'($urandom % 16 == 0), 1'($urandom % 5 == 0), dh, dl,
                       1'($urandom % 10 < 7), 1'($urandom % 2)));
      end
      test_seq("random", sel, v);
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(-1, mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    @(posedge CLK);
    #1;
    test_reset();
    test_count_up();
    test_range_1_12();
    test_load();
    test_priority();
    test_digit_wrap();
    test_rst_mid();
    test_cascade();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
